// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU CPU-side port: region map, DMA states and read-source selects.
// Also holds the echo-RAM source page mapping used by OAM DMA.
package ppu_pkg;

    localparam logic [15:0] VRAM_BASE    = 16'h8000;
    localparam logic [15:0] VRAM_LIMIT   = 16'h9FFF;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    // End of the whole OAM page block, including the unused tail after the object table
    localparam logic [15:0] OAM_LIMIT    = 16'hFEFF;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

    localparam logic [7:0]  BUS_IDLE     = 8'hFF;
    localparam logic [7:0]  ECHO_BASE    = 8'hE0;
    localparam logic [7:0]  ECHO_OFFSET  = 8'h20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        COPY  = 2'd2,
        FLUSH = 2'd3
    } dma_state_t;

    typedef enum logic [2:0] {
        RD_FF   = 3'd0,
        RD_ZERO = 3'd1,
        RD_VRAM = 3'd2,
        RD_OAM  = 3'd3,
        RD_REG  = 3'd4
    } rd_sel_t;

    function automatic logic [7:0] dma_src_hi(input logic [7:0] page);
        return (page >= ECHO_BASE) ? page - ECHO_OFFSET : page;
    endfunction

endpackage

// File: rtl/ppu_cpu_port_if.sv
// CPU bus as seen by the PPU port: address/data/strobes in, hit and read data back.
interface ppu_cpu_port_if;

    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_wren;
    logic        cpu_rden;
    logic        cpu_hit;
    logic [7:0]  cpu_rdata;

    modport master (
        output cpu_addr, cpu_wdata, cpu_wren, cpu_rden,
        input  cpu_hit, cpu_rdata
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_wren, cpu_rden,
        output cpu_hit, cpu_rdata
    );

endinterface

// File: rtl/ppu_cpu_port_sync2.sv
// Two-flop synchroniser bringing a PPU-domain level into the CPU clock domain.
module sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ppu_cpu_port.sv
// CPU-side responder for VRAM, OAM and the DMA register, with ownership gating
// against the PPU busy flags and the OAM DMA copy engine.
module ppu_cpu_port
    import ppu_pkg::*;
#(
    parameter int OAM_BYTES = 160,
    parameter int DMA_DELAY = 1
) (
    input  logic          cpu_clock,
    input  logic          reset,
    ppu_cpu_port_if.slave cpu,
    input  logic          ppu_vram_busy,
    input  logic          ppu_oam_busy,
    output logic [12:0]   vram_addr,
    output logic [7:0]    vram_wdata,
    output logic          vram_wren,
    input  logic [7:0]    vram_rdata,
    output logic [7:0]    oam_addr,
    output logic [7:0]    oam_wdata,
    output logic          oam_wren,
    input  logic [7:0]    oam_rdata,
    output logic [15:0]   dma_addr,
    output logic          dma_rden,
    input  logic [7:0]    dma_rdata,
    output logic          dma_active
);

    localparam logic [15:0] OAM_END    = OAM_BASE + 16'(OAM_BYTES);
    localparam logic [7:0]  LAST_IDX   = 8'(OAM_BYTES - 1);
    localparam logic [7:0]  DELAY_LAST = 8'(DMA_DELAY - 1);

    logic       vram_busy;
    logic       oam_busy;

    logic       in_vram;
    logic       in_oam;
    logic       in_oam_pad;
    logic       in_dma_reg;

    dma_state_t state;
    dma_state_t state_next;
    logic [7:0] idx;
    logic [7:0] idx_next;
    logic [7:0] delay_cnt;
    logic [7:0] delay_cnt_next;
    logic [7:0] dma_reg;
    logic       dma_start;

    logic       dma_wr_vld_p1;
    logic [7:0] dma_wr_idx_p1;

    logic       vram_ok;
    logic       oam_ok;

    rd_sel_t    rd_sel_p0;
    rd_sel_t    rd_sel_p1;
    logic [7:0] rd_reg_p1;

    sync2 u_vram_sync (
        .clock (cpu_clock),
        .reset (reset),
        .d     (ppu_vram_busy),
        .q     (vram_busy)
    );

    sync2 u_oam_sync (
        .clock (cpu_clock),
        .reset (reset),
        .d     (ppu_oam_busy),
        .q     (oam_busy)
    );

    always_comb begin
        in_vram    = (cpu.cpu_addr >= VRAM_BASE) && (cpu.cpu_addr <= VRAM_LIMIT);
        in_oam     = (cpu.cpu_addr >= OAM_BASE)  && (cpu.cpu_addr <  OAM_END);
        in_oam_pad = (cpu.cpu_addr >= OAM_END)   && (cpu.cpu_addr <= OAM_LIMIT);
        in_dma_reg = (cpu.cpu_addr == DMA_REG_ADDR);
    end

    assign cpu.cpu_hit = in_vram | in_oam | in_oam_pad | in_dma_reg;

    assign dma_start  = cpu.cpu_wren & in_dma_reg;
    assign dma_active = (state != IDLE);
    assign vram_ok    = ~vram_busy;
    // A pending DMA write owns the OAM port, so any CPU access that cycle counts as blocked
    assign oam_ok     = ~oam_busy & ~dma_active & ~dma_wr_vld_p1;

    always_comb begin
        state_next     = state;
        idx_next       = idx;
        delay_cnt_next = delay_cnt;
        case (state)
            IDLE: begin
                state_next = IDLE;
            end
            DELAY: begin
                if (delay_cnt == DELAY_LAST) begin
                    state_next = COPY;
                end else begin
                    delay_cnt_next = delay_cnt + 8'd1;
                end
            end
            COPY: begin
                idx_next = idx + 8'd1;
                if (idx == LAST_IDX) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // A register write restarts from byte 0 whatever the engine was doing
        if (dma_start) begin
            state_next     = (DMA_DELAY == 0) ? COPY : DELAY;
            idx_next       = 8'd0;
            delay_cnt_next = 8'd0;
        end
    end

    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 8'd0;
            delay_cnt <= 8'd0;
            dma_reg   <= 8'h00;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            delay_cnt <= delay_cnt_next;
            if (dma_start) begin
                dma_reg <= cpu.cpu_wdata;
            end
        end
    end

    assign dma_addr = {dma_src_hi(dma_reg), idx};
    assign dma_rden = (state == COPY) & ~reset;

    // Stage p0 -> p1: source read issued, OAM write of that byte follows
    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            dma_wr_vld_p1 <= 1'b0;
        end else begin
            dma_wr_vld_p1 <= (state == COPY);
        end
    end

    always_ff @(posedge cpu_clock) begin
        dma_wr_idx_p1 <= idx;
    end

    assign vram_addr  = cpu.cpu_addr[12:0];
    assign vram_wdata = cpu.cpu_wdata;
    assign vram_wren  = cpu.cpu_wren & in_vram & vram_ok & ~reset;

    assign oam_addr  = dma_wr_vld_p1 ? dma_wr_idx_p1 : cpu.cpu_addr[7:0];
    assign oam_wdata = dma_wr_vld_p1 ? dma_rdata : cpu.cpu_wdata;
    assign oam_wren  = ~reset & (dma_wr_vld_p1 | (cpu.cpu_wren & in_oam & oam_ok));

    always_comb begin
        rd_sel_p0 = RD_FF;
        if (cpu.cpu_rden) begin
            if (in_vram) begin
                rd_sel_p0 = vram_ok ? RD_VRAM : RD_FF;
            end else if (in_oam) begin
                rd_sel_p0 = oam_ok ? RD_OAM : RD_FF;
            end else if (in_oam_pad) begin
                rd_sel_p0 = RD_ZERO;
            end else if (in_dma_reg) begin
                rd_sel_p0 = RD_REG;
            end
        end
    end

    // Stage p0 -> p1: read source chosen at request time, RAM data arrives one cycle later
    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            rd_sel_p1 <= RD_FF;
        end else begin
            rd_sel_p1 <= rd_sel_p0;
        end
    end

    always_ff @(posedge cpu_clock) begin
        rd_reg_p1 <= dma_reg;
    end

    always_comb begin
        cpu.cpu_rdata = BUS_IDLE;
        case (rd_sel_p1)
            RD_ZERO: cpu.cpu_rdata = 8'h00;
            RD_VRAM: cpu.cpu_rdata = vram_rdata;
            RD_OAM:  cpu.cpu_rdata = oam_rdata;
            RD_REG:  cpu.cpu_rdata = rd_reg_p1;
            default: cpu.cpu_rdata = BUS_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ppu_cpu_port.sv
// Directed bench for ppu_cpu_port: table of single CPU accesses, then DMA sequences
// (plain copy, echo page, restart mid-copy, reset mid-copy) against behavioural RAMs.
module tb_ppu_cpu_port;

    logic        cpu_clock = 1'b0;
    logic        reset;
    logic        ppu_vram_busy;
    logic        ppu_oam_busy;
    logic [12:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_wren;
    logic [7:0]  vram_rdata;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_wren;
    logic [7:0]  oam_rdata;
    logic [15:0] dma_addr;
    logic        dma_rden;
    logic [7:0]  dma_rdata;
    logic        dma_active;

    ppu_cpu_port_if bus ();

    ppu_cpu_port #(.OAM_BYTES(160), .DMA_DELAY(1)) dut (
        .cpu_clock     (cpu_clock),
        .reset         (reset),
        .cpu           (bus),
        .ppu_vram_busy (ppu_vram_busy),
        .ppu_oam_busy  (ppu_oam_busy),
        .vram_addr     (vram_addr),
        .vram_wdata    (vram_wdata),
        .vram_wren     (vram_wren),
        .vram_rdata    (vram_rdata),
        .oam_addr      (oam_addr),
        .oam_wdata     (oam_wdata),
        .oam_wren      (oam_wren),
        .oam_rdata     (oam_rdata),
        .dma_addr      (dma_addr),
        .dma_rden      (dma_rden),
        .dma_rdata     (dma_rdata),
        .dma_active    (dma_active)
    );

    always #5 cpu_clock = ~cpu_clock;

    // System memory seen by the DMA: page C0 holds i^0x33
    function automatic logic [7:0] src_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hF3;
    endfunction

    logic [7:0] vram_mem [0:8191];
    logic [7:0] oam_mem  [0:255];

    always @(posedge cpu_clock) begin
        if (vram_wren) vram_mem[vram_addr] <= vram_wdata;
        vram_rdata <= vram_mem[vram_addr];
        if (oam_wren) oam_mem[oam_addr] <= oam_wdata;
        oam_rdata <= oam_mem[oam_addr];
        dma_rdata <= src_byte(dma_addr);
    end

    int cyc = 0;
    always @(posedge cpu_clock) cyc <= cyc + 1;

    int          clr_req = 0;
    int          clr_seen = 0;
    int          wr_cnt, rd_cnt, first_act, last_act, last_wr;
    logic [15:0] first_da, last_da;

    always @(negedge cpu_clock) begin
        if (clr_req != clr_seen) begin
            clr_seen  = clr_req;
            wr_cnt    = 0;
            rd_cnt    = 0;
            first_act = -1;
            last_act  = -1;
            last_wr   = -1;
            first_da  = 16'h0000;
            last_da   = 16'h0000;
        end
        if (oam_wren) begin
            wr_cnt++;
            last_wr = cyc;
        end
        if (dma_rden) begin
            if (rd_cnt == 0) first_da = dma_addr;
            last_da = dma_addr;
            rd_cnt++;
        end
        if (dma_active) begin
            if (first_act < 0) first_act = cyc;
            last_act = cyc;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clock);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic cpu_op(input logic wr, input logic rd, input logic [15:0] a, input logic [7:0] d,
                          output logic hit, output logic vwr, output logic owr, output logic [7:0] rdata);
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_wren  = wr;
        bus.cpu_rden  = rd;
        #1;
        hit = bus.cpu_hit;
        vwr = vram_wren;
        owr = oam_wren;
        tick();
        bus.cpu_wren = 1'b0;
        bus.cpu_rden = 1'b0;
        bus.cpu_addr = 16'h0000;
        #1;
        rdata = bus.cpu_rdata;
    endtask

    task automatic check_image(input string name, input logic [7:0] page);
        int bad = 0;
        for (int i = 0; i < 160; i++) begin
            if (oam_mem[i] !== src_byte({page, 8'(i)})) bad++;
        end
        check(name, bad, 0);
    endtask

    typedef struct {
        string       name;
        logic        wr;
        logic        rd;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        vbusy;
        logic        obusy;
        logic        hit;
        logic        vwr;
        logic        owr;
        logic        chk_rd;
        logic [7:0]  rdata;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    logic       hit, vwr, owr;
    logic [7:0] rdata;
    int         s, s2;

    initial begin
        vecs[0]  = '{"vram_wr_idle", 1'b1, 1'b0, 16'h8010, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{"vram_rd_idle", 1'b0, 1'b1, 16'h8010, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A};
        vecs[2]  = '{"vram_wr_busy", 1'b1, 1'b0, 16'h8010, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{"vram_rd_busy", 1'b0, 1'b1, 16'h8010, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF};
        vecs[4]  = '{"vram_rd_kept", 1'b0, 1'b1, 16'h8010, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A};
        vecs[5]  = '{"vram_wr_top",  1'b1, 1'b0, 16'h9FFF, 8'hAB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{"vram_rd_top",  1'b0, 1'b1, 16'h9FFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hAB};
        vecs[7]  = '{"oam_wr_idle",  1'b1, 1'b0, 16'hFE05, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[8]  = '{"oam_rd_idle",  1'b0, 1'b1, 16'hFE05, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h77};
        vecs[9]  = '{"oam_wr_busy",  1'b1, 1'b0, 16'hFE05, 8'h88, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{"oam_rd_busy",  1'b0, 1'b1, 16'hFE05, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF};
        vecs[11] = '{"oam_rd_kept",  1'b0, 1'b1, 16'hFE05, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h77};
        vecs[12] = '{"oam_wr_last",  1'b1, 1'b0, 16'hFE9F, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[13] = '{"oam_rd_last",  1'b0, 1'b1, 16'hFE9F, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C};
        vecs[14] = '{"pad_rd_first", 1'b0, 1'b1, 16'hFEA0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[15] = '{"pad_wr",       1'b1, 1'b0, 16'hFEFF, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[16] = '{"pad_rd_last",  1'b0, 1'b1, 16'hFEFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[17] = '{"miss_rd",      1'b0, 1'b1, 16'hC000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF};
        vecs[18] = '{"miss_wr",      1'b1, 1'b0, 16'h7FFF, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[19] = '{"ff46_rd_rst",  1'b0, 1'b1, 16'hFF46, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[20] = '{"miss_ff47",    1'b0, 1'b1, 16'hFF47, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF};

        reset         = 1'b1;
        ppu_vram_busy = 1'b0;
        ppu_oam_busy  = 1'b0;
        bus.cpu_addr  = 16'h0000;
        bus.cpu_wdata = 8'h00;
        bus.cpu_wren  = 1'b0;
        bus.cpu_rden  = 1'b0;
        repeat (3) tick();
        check("rst_dma_active", dma_active, 1'b0);
        check("rst_rdata", bus.cpu_rdata, 8'hFF);
        check("rst_dma_rden", dma_rden, 1'b0);
        reset = 1'b0;
        tick();
        check("post_rst_rdata", bus.cpu_rdata, 8'hFF);
        check("post_rst_oam_wren", oam_wren, 1'b0);
        check("post_rst_vram_wren", vram_wren, 1'b0);

        for (int k = 0; k < NV; k++) begin
            if (ppu_vram_busy !== vecs[k].vbusy || ppu_oam_busy !== vecs[k].obusy) begin
                ppu_vram_busy = vecs[k].vbusy;
                ppu_oam_busy  = vecs[k].obusy;
                repeat (3) tick();
            end
            cpu_op(vecs[k].wr, vecs[k].rd, vecs[k].addr, vecs[k].wdata, hit, vwr, owr, rdata);
            check({vecs[k].name, "_hit"}, hit, vecs[k].hit);
            check({vecs[k].name, "_vram_wren"}, vwr, vecs[k].vwr);
            check({vecs[k].name, "_oam_wren"}, owr, vecs[k].owr);
            if (vecs[k].chk_rd) check({vecs[k].name, "_rdata"}, rdata, vecs[k].rdata);
        end

        // Plain copy from page C0 with CPU OAM traffic in the middle
        s = cyc;
        clr_req++;
        cpu_op(1'b1, 1'b0, 16'hFF46, 8'hC0, hit, vwr, owr, rdata);
        check("dma_active_rise", dma_active, 1'b1);
        wait_until(s + 20);
        cpu_op(1'b0, 1'b1, 16'hFE00, 8'h00, hit, vwr, owr, rdata);
        check("dma_cpu_oam_rd", rdata, 8'hFF);
        cpu_op(1'b1, 1'b0, 16'hFE05, 8'h99, hit, vwr, owr, rdata);
        wait_until(s + 170);
        check("dma_first_active", first_act - s, 1);
        check("dma_last_active", last_act - s, 162);
        check("dma_wr_count", wr_cnt, 160);
        check("dma_last_wr", last_wr - s, 162);
        check("dma_rd_count", rd_cnt, 160);
        check("dma_first_addr", first_da, 16'hC000);
        check("dma_last_addr", last_da, 16'hC09F);
        check_image("dma_image_c0", 8'hC0);
        check("dma_oam5_kept", oam_mem[5], 8'h36);
        cpu_op(1'b0, 1'b1, 16'hFF46, 8'h00, hit, vwr, owr, rdata);
        check("ff46_rd_c0", rdata, 8'hC0);

        // Echo-RAM source page
        s = cyc;
        clr_req++;
        cpu_op(1'b1, 1'b0, 16'hFF46, 8'hE1, hit, vwr, owr, rdata);
        wait_until(s + 170);
        check("echo_first_addr", first_da, 16'hC100);
        check("echo_last_addr", last_da, 16'hC19F);
        check("echo_rd_count", rd_cnt, 160);
        check_image("echo_image_c1", 8'hC1);
        cpu_op(1'b0, 1'b1, 16'hFF46, 8'h00, hit, vwr, owr, rdata);
        check("ff46_rd_e1", rdata, 8'hE1);

        // Restart while byte 50 is being read
        s = cyc;
        cpu_op(1'b1, 1'b0, 16'hFF46, 8'hC0, hit, vwr, owr, rdata);
        wait_until(s + 52);
        clr_req++;
        s2 = cyc;
        cpu_op(1'b1, 1'b0, 16'hFF46, 8'hD0, hit, vwr, owr, rdata);
        wait_until(s2 + 170);
        check("restart_wr_count", wr_cnt, 162);
        check("restart_last_wr", last_wr - s2, 162);
        check("restart_rd_count", rd_cnt, 161);
        check("restart_first_addr", first_da, 16'hC032);
        check("restart_last_addr", last_da, 16'hD09F);
        check_image("restart_image_d0", 8'hD0);

        // Reset while byte 80 is being read
        s = cyc;
        cpu_op(1'b1, 1'b0, 16'hFF46, 8'hC0, hit, vwr, owr, rdata);
        wait_until(s + 82);
        clr_req++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstdma_active", dma_active, 1'b0);
        check("rstdma_oam_wren", oam_wren, 1'b0);
        repeat (200) tick();
        check("rstdma_wr_count", wr_cnt, 0);
        check("rstdma_rd_count", rd_cnt, 0);
        check("rstdma_last_active", last_act - s, 82);
        cpu_op(1'b0, 1'b1, 16'hFF46, 8'h00, hit, vwr, owr, rdata);
        check("rstdma_ff46", rdata, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
